// File: rtl/branch_predict_cond.sv
// Resolves EX-stage branches and jumps, predicts IF branches with a BHT of saturating
// counters, drives the PC select and sequences a registered flush. Optional BRPERF_EN adds branch/mispredict counters.
module branch_predict_cond #(
    parameter int XLEN         = 32,
    parameter int BHT_DEPTH    = 16,
    parameter int CTR_W        = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [6:0]      ex_opcode,
    input  logic [2:0]      ex_func3,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flushed,
    input  logic            int_taken,
    output logic [2:0]      pc_sel,
    output logic            flush_o,
    output logic [31:0]     br_count,
    output logic [31:0]     mispred_count
);

    // state | meaning
    // IDLE  | normal operation, EX may redirect
    // FLUSH | squashing IF/ID/EX for FLUSH_CYCLES after a redirect
    typedef enum logic {IDLE, FLUSH} state_t;

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int CNT_W = $clog2(FLUSH_CYCLES) + 1;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] SEL_PC4   = 3'b000;
    localparam logic [2:0] SEL_JALR  = 3'b001;
    localparam logic [2:0] SEL_BR    = 3'b010;
    localparam logic [2:0] SEL_JAL   = 3'b011;
    localparam logic [2:0] SEL_TRAP  = 3'b100;
    localparam logic [2:0] SEL_RECOV = 3'b101;
    localparam logic [2:0] SEL_PRED  = 3'b110;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [CTR_W-1:0] bht [BHT_DEPTH];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic             squash, br_valid, taken, redirect, bht_we;
    logic             eq, lt, ltu;
    logic [CTR_W-1:0] ctr_cur, ctr_upd;
    logic [2:0]       sel;

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                              ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

    assign if_pred_taken = bht[if_idx][CTR_W-1];
    assign squash        = flushed | (state == FLUSH);

    assign eq  = (rs1 == rs2);
    assign ltu = (rs1 < rs2);
    assign lt  = ($signed(rs1) < $signed(rs2));

    always_comb begin
        br_valid = 1'b0;
        taken    = 1'b0;
        if (ex_opcode == OP_BRANCH) begin
            br_valid = 1'b1;
            unique case (ex_func3)
                3'b000:  taken = eq;
                3'b001:  taken = !eq;
                3'b100:  taken = lt;
                3'b101:  taken = !lt;
                3'b110:  taken = ltu;
                3'b111:  taken = !ltu;
                default: br_valid = 1'b0;
            endcase
        end
    end

    always_comb begin
        sel = SEL_PC4;
        if (!rst_n)
            sel = SEL_PC4;
        else if (int_taken)
            sel = SEL_TRAP;
        else if (!squash && ex_opcode == OP_JAL)
            sel = SEL_JAL;
        else if (!squash && ex_opcode == OP_JALR)
            sel = SEL_JALR;
        else if (!squash && br_valid && taken && !ex_pred_taken)
            sel = SEL_BR;
        else if (!squash && br_valid && !taken && ex_pred_taken)
            sel = SEL_RECOV;
        else if (if_pred_taken && !squash)
            sel = SEL_PRED;
    end

    assign pc_sel   = sel;
    assign redirect = (sel != SEL_PC4) && (sel != SEL_PRED);

    // Correctly predicted branches still train the table; squashed ones never do.
    assign bht_we  = br_valid && !squash && !int_taken;
    assign ctr_cur = bht[ex_idx];

    always_comb begin
        ctr_upd = ctr_cur;
        if (taken) begin
            if (ctr_cur != {CTR_W{1'b1}})
                ctr_upd = ctr_cur + CTR_W'(1);
        end else begin
            if (ctr_cur != '0)
                ctr_upd = ctr_cur - CTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++)
                bht[i] <= CTR_W'(1);
        end else if (bht_we) begin
            bht[ex_idx] <= ctr_upd;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            IDLE: begin
                if (redirect) begin
                    state_next = FLUSH;
                    cnt_next   = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (redirect)
                    cnt_next = CNT_W'(FLUSH_CYCLES - 1);
                else if (cnt == '0)
                    state_next = IDLE;
                else
                    cnt_next = cnt - CNT_W'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            flush_o <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            flush_o <= (state_next == FLUSH);
        end
    end

`ifdef BRPERF_EN
    logic [31:0] br_q, mis_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_q  <= '0;
            mis_q <= '0;
        end else if (bht_we) begin
            br_q <= br_q + 32'd1;
            if (sel == SEL_BR || sel == SEL_RECOV)
                mis_q <= mis_q + 32'd1;
        end
    end

    assign br_count      = br_q;
    assign mispred_count = mis_q;
`else
    assign br_count      = '0;
    assign mispred_count = '0;
`endif

endmodule

// File: tb/tb_branch_predict_cond.sv
// Directed bench for branch_predict_cond: vector table for the compare/priority logic,
// plus sequences for flush timing, BHT training/saturation and the optional BRPERF_EN counters.
module tb_branch_predict_cond;

    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ALU  = 7'b0110011;
    localparam logic [6:0] OP_NOP  = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc, ex_pc, rs1, rs2;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_func3;
    logic        ex_pred_taken, flushed, int_taken;
    logic        if_pred_taken, flush_o;
    logic [2:0]  pc_sel;
    logic [31:0] br_count, mispred_count;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predict_cond dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .ex_pc         (ex_pc),
        .ex_opcode     (ex_opcode),
        .ex_func3      (ex_func3),
        .ex_pred_taken (ex_pred_taken),
        .rs1           (rs1),
        .rs2           (rs2),
        .flushed       (flushed),
        .int_taken     (int_taken),
        .pc_sel        (pc_sel),
        .flush_o       (flush_o),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic        pred;
        logic        fl;
        logic        it;
        logic [2:0]  exp_sel;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ex(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic pred, input logic fl, input logic it);
        ex_opcode     = op;
        ex_func3      = f3;
        rs1           = a;
        rs2           = b;
        ex_pred_taken = pred;
        flushed       = fl;
        int_taken     = it;
    endtask

    task automatic idle_ex();
        set_ex(OP_NOP, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_ex();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic tk_seq  [9];
        logic exp_pre [9];
        logic mis_seq [10];
        logic fl_seq  [10];
        logic [31:0] exp_br, exp_mis;

        vecs[0]  = '{OP_B,   3'b000, 32'd5,        32'd5,        1'b0, 1'b0, 1'b0, 3'b010};
        vecs[1]  = '{OP_B,   3'b000, 32'd5,        32'd6,        1'b0, 1'b0, 1'b0, 3'b000};
        vecs[2]  = '{OP_B,   3'b000, 32'd5,        32'd6,        1'b1, 1'b0, 1'b0, 3'b101};
        vecs[3]  = '{OP_B,   3'b001, 32'd5,        32'd6,        1'b1, 1'b0, 1'b0, 3'b000};
        vecs[4]  = '{OP_B,   3'b001, 32'd5,        32'd5,        1'b1, 1'b0, 1'b0, 3'b101};
        vecs[5]  = '{OP_B,   3'b100, 32'hFFFFFFFF, 32'd1,        1'b1, 1'b0, 1'b0, 3'b000};
        vecs[6]  = '{OP_B,   3'b110, 32'hFFFFFFFF, 32'd1,        1'b1, 1'b0, 1'b0, 3'b101};
        vecs[7]  = '{OP_B,   3'b101, 32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 3'b010};
        vecs[8]  = '{OP_B,   3'b111, 32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 3'b000};
        vecs[9]  = '{OP_B,   3'b010, 32'd5,        32'd5,        1'b1, 1'b0, 1'b0, 3'b000};
        vecs[10] = '{OP_B,   3'b011, 32'd5,        32'd5,        1'b0, 1'b0, 1'b0, 3'b000};
        vecs[11] = '{OP_JAL, 3'b000, 32'd0,        32'd0,        1'b0, 1'b0, 1'b0, 3'b011};
        vecs[12] = '{OP_JALR,3'b000, 32'd0,        32'd0,        1'b0, 1'b0, 1'b0, 3'b001};
        vecs[13] = '{OP_JAL, 3'b000, 32'd0,        32'd0,        1'b0, 1'b1, 1'b0, 3'b000};
        vecs[14] = '{OP_JAL, 3'b000, 32'd0,        32'd0,        1'b0, 1'b0, 1'b1, 3'b100};
        vecs[15] = '{OP_B,   3'b000, 32'd5,        32'd5,        1'b0, 1'b1, 1'b0, 3'b000};
        vecs[16] = '{OP_ALU, 3'b000, 32'd5,        32'd5,        1'b1, 1'b0, 1'b0, 3'b000};

        // Reset state, with a JAL present to show pc_sel is forced during reset
        rst_n = 1'b0;
        if_pc = 32'h40;
        ex_pc = 32'h300;
        idle_ex();
        @(negedge clk);
        tick();
        ex_opcode = OP_JAL;
        #1 check("reset_pc_sel_forced", {29'd0, pc_sel}, 32'd0);
        idle_ex();
        rst_n = 1'b1;
        #1;
        check("reset_if_pred", {31'd0, if_pred_taken}, 32'd0);
        check("reset_flush", {31'd0, flush_o}, 32'd0);
        check("reset_pc_sel", {29'd0, pc_sel}, 32'd0);

        // Compare/priority vectors; each is reset away before its clock edge commits
        for (int i = 0; i < 17; i++) begin
            do_reset();
            if_pc = 32'h100;
            ex_pc = 32'h300;
            set_ex(vecs[i].op, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].pred, vecs[i].fl, vecs[i].it);
            #1 check($sformatf("vec%0d_pc_sel", i), {29'd0, pc_sel}, {29'd0, vecs[i].exp_sel});
        end

        // Mispredicted BEQ: redirect, two flush cycles, BHT trained toward taken
        do_reset();
        if_pc = 32'h40;
        ex_pc = 32'h40;
        set_ex(OP_B, 3'b000, 32'd5, 32'd5, 1'b0, 1'b0, 1'b0);
        #1 check("beq_redirect", {29'd0, pc_sel}, 32'd2);
        check("beq_flush_before", {31'd0, flush_o}, 32'd0);
        tick();
        idle_ex();
        #1 check("beq_flush_c1", {31'd0, flush_o}, 32'd1);
        check("beq_bht_trained", {31'd0, if_pred_taken}, 32'd1);
        check("beq_pred_squashed", {29'd0, pc_sel}, 32'd0);
        tick();
        #1 check("beq_flush_c2", {31'd0, flush_o}, 32'd1);
        tick();
        #1 check("beq_flush_end", {31'd0, flush_o}, 32'd0);
        check("beq_pred_sel", {29'd0, pc_sel}, 32'd6);

        // Saturation at index 3 using correctly predicted BGEU; values shown are pre-update
        tk_seq  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_pre = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        if_pc = 32'h0C;
        ex_pc = 32'h0C;
        for (int i = 0; i < 9; i++) begin
            if (tk_seq[i])
                set_ex(OP_B, 3'b111, 32'd5, 32'd5, 1'b1, 1'b0, 1'b0);
            else
                set_ex(OP_B, 3'b111, 32'd1, 32'd5, 1'b0, 1'b0, 1'b0);
            #1 check($sformatf("sat%0d_pred", i), {31'd0, if_pred_taken}, {31'd0, exp_pre[i]});
            check($sformatf("sat%0d_sel", i), {29'd0, pc_sel}, exp_pre[i] ? 32'd6 : 32'd0);
            tick();
        end
        idle_ex();
        #1 check("sat_final_pred", {31'd0, if_pred_taken}, 32'd0);

        // Interrupt with JAL, JAL blocked in FLUSH, interrupt re-arming the flush
        do_reset();
        if_pc = 32'h100;
        ex_pc = 32'h300;
        set_ex(OP_JAL, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        #1 check("int_jal_sel", {29'd0, pc_sel}, 32'd4);
        tick();
        set_ex(OP_JAL, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        #1 check("int_flush_c1", {31'd0, flush_o}, 32'd1);
        check("jal_in_flush_sel", {29'd0, pc_sel}, 32'd0);
        tick();
        set_ex(OP_NOP, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        #1 check("int2_sel", {29'd0, pc_sel}, 32'd4);
        check("int_flush_c2", {31'd0, flush_o}, 32'd1);
        tick();
        idle_ex();
        #1 check("int_reload_c1", {31'd0, flush_o}, 32'd1);
        tick();
        #1 check("int_reload_c2", {31'd0, flush_o}, 32'd1);
        tick();
        #1 check("int_reload_end", {31'd0, flush_o}, 32'd0);

        // Reset in the middle of a flush sequence
        do_reset();
        set_ex(OP_JAL, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        #1 check("rstmid_jal_sel", {29'd0, pc_sel}, 32'd3);
        tick();
        #1 check("rstmid_flush_on", {31'd0, flush_o}, 32'd1);
        rst_n = 1'b0;
        #1 check("rstmid_sel_forced", {29'd0, pc_sel}, 32'd0);
        tick();
        rst_n = 1'b1;
        idle_ex();
        #1 check("rstmid_flush_off", {31'd0, flush_o}, 32'd0);

        // Perf counters: 10 branches, 3 mispredicted, 1 squashed by flushed
        mis_seq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        fl_seq  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        if_pc = 32'h100;
        ex_pc = 32'h204;
        for (int i = 0; i < 10; i++) begin
            if (mis_seq[i])
                set_ex(OP_B, 3'b000, 32'd5, 32'd5, 1'b0, fl_seq[i], 1'b0);
            else
                set_ex(OP_B, 3'b000, 32'd5, 32'd6, 1'b0, fl_seq[i], 1'b0);
            tick();
            idle_ex();
            tick();
            tick();
            tick();
        end
`ifdef BRPERF_EN
        exp_br  = 32'd9;
        exp_mis = 32'd3;
`else
        exp_br  = 32'd0;
        exp_mis = 32'd0;
`endif
        #1 check("perf_br_count", br_count, exp_br);
        check("perf_mispred_count", mispred_count, exp_mis);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
